// File: rtl/slave_responder_pkg.sv
// Shared types and constants for the slave_responder block.
//   t_resp_st : responder FSM states
//   ERR_DATA  : read data returned for an out-of-range read when the
//               SLV_ERR_RESP_EN build option is defined
package slave_responder_pkg;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_ACK,
    R_HOLD
  } t_resp_st;

  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/slave_responder_if.sv
// Request/response bundle between a cross_bar slave port and its target.
//   req   : request valid, held with cmd/addr/wdata until ack is seen
//   cmd   : 1 = write, 0 = read
//   addr  : word address (bit 31 is the cross_bar slave select)
//   wdata : write data
//   ack   : one-cycle completion pulse
//   rdata : read data, valid with ack for reads
//   err   : address error, valid with ack
//   busy  : target is not idle
interface slave_responder_if;

  logic        req;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  modport master (
    output req, cmd, addr, wdata,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, cmd, addr, wdata,
    output ack, rdata, err, busy
  );

endinterface

// File: rtl/slave_responder_mem.sv
// DEPTH x 32 single-port synchronous RAM with registered read.
//   clk   : clock
//   we    : write enable
//   idx   : word index
//   wdata : write data
//   rdata : registered read data (old contents on a same-cycle write)
// Contents are not reset.
module slave_responder_mem #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/slave_responder.sv
// Memory-backed responder behind one cross_bar slave port. Accepts one held
// request, waits WAIT_CYC cycles, then pulses ack for one cycle (with read
// data for reads). A request still held after its ack is not served again.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave_responder_if.slave (req/cmd/addr/wdata in, ack/rdata/err/busy out)
// Build option SLV_ERR_RESP_EN: nonzero address bits [30:$clog2(DEPTH)] flag
// an error; such writes are dropped and such reads return ERR_DATA. Without
// it those bits are ignored (address wraps modulo DEPTH) and err is 0.
module slave_responder
  import slave_responder_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int WAIT_CYC = 2
) (
  input logic               clk,
  input logic               rst_n,
  slave_responder_if.slave  bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LEN = 4'(WAIT_CYC);

  t_resp_st          state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              cmd_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [31:0]       wdata_reg;
  logic              oor_reg;

  logic              accept;
  logic              addr_oor;
  logic              sel_cmd;
  logic [IDX_W-1:0]  sel_idx;
  logic [31:0]       sel_wdata;
  logic              sel_oor;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  logic              unused_addr;

`ifdef SLV_ERR_RESP_EN
  assign addr_oor    = |bus.addr[30:IDX_W];
  assign unused_addr = bus.addr[31];
`else
  assign addr_oor    = 1'b0;
  assign unused_addr = ^bus.addr[31:IDX_W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= R_IDLE;
      cnt_reg   <= '0;
      cmd_reg   <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      oor_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        cmd_reg   <= bus.cmd;
        idx_reg   <= bus.addr[IDX_W-1:0];
        wdata_reg <= bus.wdata;
        oor_reg   <= addr_oor;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      R_IDLE: begin
        if (bus.req) begin
          accept     = 1'b1;
          cnt_next   = 4'd1;
          state_next = (WAIT_CYC == 0) ? R_ACK : R_WAIT;
        end
      end
      R_WAIT: begin
        if (cnt_reg == WAIT_LEN) begin
          state_next = R_ACK;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      R_ACK: begin
        cnt_next   = '0;
        state_next = R_HOLD;
      end
      R_HOLD: begin
        if (!bus.req) begin
          state_next = R_IDLE;
        end
      end
      default: state_next = R_IDLE;
    endcase
  end

  // With WAIT_CYC=0 the edge that accepts the request is also the edge that
  // enters R_ACK, so the live bus fields must feed the RAM on that edge.
  assign sel_cmd   = accept ? bus.cmd              : cmd_reg;
  assign sel_idx   = accept ? bus.addr[IDX_W-1:0]  : idx_reg;
  assign sel_wdata = accept ? bus.wdata            : wdata_reg;
  assign sel_oor   = accept ? addr_oor             : oor_reg;

  // Write commits, and read data is captured, on the edge entering R_ACK.
  // A reset before that edge leaves the RAM untouched.
  assign mem_we = (state_next == R_ACK) && sel_cmd && !sel_oor;

  slave_responder_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (sel_idx),
    .wdata (sel_wdata),
    .rdata (mem_rdata)
  );

  assign bus.ack   = (state_reg == R_ACK);
  assign bus.busy  = (state_reg != R_IDLE);
  assign bus.rdata = (bus.ack && !cmd_reg) ? (oor_reg ? ERR_DATA : mem_rdata) : '0;

`ifdef SLV_ERR_RESP_EN
  assign bus.err = bus.ack && oor_reg;
`else
  assign bus.err = 1'b0;
`endif

endmodule
